// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit and the EX-stage operand
// mux decode: default widths, select encodings and FSM state codes.
package fwd_hazard_unit_pkg;

    localparam int NB_REG       = 5;
    localparam int N_FWD_STAGES = 2;
    localparam int NB_MUX_FW    = $clog2(N_FWD_STAGES + 1);

    // Operand mux select encodings: 0 keeps the ID/EX value, s+1 picks stage s.
    localparam int FROM_ID_EX  = 0;
    localparam int FROM_EX_MEM = 1;
    localparam int FROM_MEM_WB = 2;

    // Load-use stall FSM state codes.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // Select value that routes forwarding stage s onto an operand.
    function automatic int stage_sel(input int s);
        return s + 1;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_select.sv
// Priority match of one EX operand index against all forwarding stages.
// The nearest stage (lowest slice) wins; register 0 is never forwarded.
module fwd_select #(
    parameter int NB_REG       = fwd_hazard_unit_pkg::NB_REG,
    parameter int N_FWD_STAGES = fwd_hazard_unit_pkg::N_FWD_STAGES,
    parameter int NB_MUX_FW    = $clog2(N_FWD_STAGES + 1)
) (
    input  logic [NB_REG-1:0]              i_src,
    input  logic [N_FWD_STAGES*NB_REG-1:0] i_fwd_rd,
    input  logic [N_FWD_STAGES-1:0]        i_fwd_wr_en,
    output logic [NB_MUX_FW-1:0]           o_sel
);
    import fwd_hazard_unit_pkg::*;

    // Scan farthest to nearest so the nearest matching stage overrides.
    always_comb begin
        o_sel = NB_MUX_FW'(FROM_ID_EX);
        for (int s = N_FWD_STAGES - 1; s >= 0; s--) begin
            if (i_fwd_wr_en[s] &&
                (i_fwd_rd[s*NB_REG +: NB_REG] != '0) &&
                (i_fwd_rd[s*NB_REG +: NB_REG] == i_src))
                o_sel = NB_MUX_FW'(stage_sel(s));
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects plus load-use stall FSM for the MIPS pipeline.
// Stalls are combinational in the detection cycle, then driven by the FSM for
// the remaining LOAD_LAT-1 cycles while ID/EX carries a bubble.
module fwd_hazard_unit #(
    parameter int NB_REG       = fwd_hazard_unit_pkg::NB_REG,
    parameter int N_SRC        = 2,
    parameter int N_FWD_STAGES = fwd_hazard_unit_pkg::N_FWD_STAGES,
    parameter int LOAD_LAT     = 1,
    parameter int NB_MUX_FW    = $clog2(N_FWD_STAGES + 1),
    parameter int NB_CNT       = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_SRC*NB_REG-1:0]       i_id_ex_src,
    input  logic [N_FWD_STAGES*NB_REG-1:0] i_fwd_rd,
    input  logic [N_FWD_STAGES-1:0]       i_fwd_wr_en,
    input  logic [N_SRC*NB_REG-1:0]       i_id_src,
    input  logic                          i_id_valid,
    input  logic [NB_REG-1:0]             i_id_ex_rd,
    input  logic                          i_id_ex_mem_rd,
    input  logic                          i_flush,
    output logic [N_SRC*NB_MUX_FW-1:0]    o_mux_sel,
    output logic                          o_stall_pc,
    output logic                          o_stall_if_id,
    output logic                          o_bubble_id_ex,
    output logic [NB_CNT-1:0]             o_stall_cnt
);
    import fwd_hazard_unit_pkg::*;

    // A one-cycle stall needs no counter state; keep one bit so the
    // declaration stays legal.
    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    logic [N_SRC*NB_MUX_FW-1:0] sel_raw;
    logic [0:0]                 state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic                       src_hit, hazard, stall_now;

    genvar k;
    generate
        for (k = 0; k < N_SRC; k++) begin : g_sel
            fwd_select #(
                .NB_REG      (NB_REG),
                .N_FWD_STAGES(N_FWD_STAGES),
                .NB_MUX_FW   (NB_MUX_FW)
            ) u_fwd_select (
                .i_src      (i_id_ex_src[k*NB_REG +: NB_REG]),
                .i_fwd_rd   (i_fwd_rd),
                .i_fwd_wr_en(i_fwd_wr_en),
                .o_sel      (sel_raw[k*NB_MUX_FW +: NB_MUX_FW])
            );
        end
    endgenerate

    // Selects are forced to the ID/EX value while reset is held.
    assign o_mux_sel = i_rst ? sel_raw : '0;

    // Load-use detection: a valid ID instruction reads the pending load target.
    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (i_id_src[i*NB_REG +: NB_REG] == i_id_ex_rd)
                src_hit = 1'b1;
        end
        hazard = i_id_valid && i_id_ex_mem_rd && (i_id_ex_rd != '0) && src_hit;
    end

    // Stall request: flush and reset both override; in STALL, H is ignored.
    always_comb begin
        stall_now = 1'b0;
        if (i_rst && !i_flush) begin
            if (state == ST_STALL)
                stall_now = 1'b1;
            else
                stall_now = hazard;
        end
    end

    assign o_stall_pc     = stall_now;
    assign o_stall_if_id  = stall_now;
    assign o_bubble_id_ex = stall_now;

    // Next-state logic for the stall sequencer and its down-counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (i_flush) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state_nxt = ST_STALL;
                        cnt_nxt   = CNT_W'(LOAD_LAT - 1);
                    end
                end
                ST_STALL: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating count of stall cycles for performance monitoring.
    always_ff @(posedge i_clk) begin
        if (!i_rst)
            o_stall_cnt <= '0;
        else if (stall_now && (o_stall_cnt != '1))
            o_stall_cnt <= o_stall_cnt + NB_CNT'(1);
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: three instances cover LOAD_LAT=1 with a 2-bit counter,
// LOAD_LAT=3, and a 3-source/3-stage build with LOAD_LAT=2.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id_ex_src, fwd_rd, id_src;
    logic [1:0]  fwd_wr_en;
    logic        id_valid, id_ex_mem_rd, flush;
    logic [4:0]  id_ex_rd;

    logic [3:0]  a_mux, b_mux;
    logic        a_pc, a_ifid, a_bub, b_pc, b_ifid, b_bub;
    logic [1:0]  a_cnt;
    logic [31:0] b_cnt;

    logic [14:0] c_id_ex_src, c_fwd_rd, c_id_src;
    logic [2:0]  c_wr_en;
    logic [5:0]  c_mux;
    logic        c_pc, c_ifid, c_bub;
    logic [31:0] c_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.LOAD_LAT(1), .NB_CNT(2)) u_a (
        .i_clk(clk), .i_rst(rst), .i_id_ex_src(id_ex_src), .i_fwd_rd(fwd_rd),
        .i_fwd_wr_en(fwd_wr_en), .i_id_src(id_src), .i_id_valid(id_valid),
        .i_id_ex_rd(id_ex_rd), .i_id_ex_mem_rd(id_ex_mem_rd), .i_flush(flush),
        .o_mux_sel(a_mux), .o_stall_pc(a_pc), .o_stall_if_id(a_ifid),
        .o_bubble_id_ex(a_bub), .o_stall_cnt(a_cnt));

    fwd_hazard_unit #(.LOAD_LAT(3)) u_b (
        .i_clk(clk), .i_rst(rst), .i_id_ex_src(id_ex_src), .i_fwd_rd(fwd_rd),
        .i_fwd_wr_en(fwd_wr_en), .i_id_src(id_src), .i_id_valid(id_valid),
        .i_id_ex_rd(id_ex_rd), .i_id_ex_mem_rd(id_ex_mem_rd), .i_flush(flush),
        .o_mux_sel(b_mux), .o_stall_pc(b_pc), .o_stall_if_id(b_ifid),
        .o_bubble_id_ex(b_bub), .o_stall_cnt(b_cnt));

    fwd_hazard_unit #(.N_SRC(3), .N_FWD_STAGES(3), .LOAD_LAT(2)) u_c (
        .i_clk(clk), .i_rst(rst), .i_id_ex_src(c_id_ex_src), .i_fwd_rd(c_fwd_rd),
        .i_fwd_wr_en(c_wr_en), .i_id_src(c_id_src), .i_id_valid(id_valid),
        .i_id_ex_rd(id_ex_rd), .i_id_ex_mem_rd(id_ex_mem_rd), .i_flush(flush),
        .o_mux_sel(c_mux), .o_stall_pc(c_pc), .o_stall_if_id(c_ifid),
        .o_bubble_id_ex(c_bub), .o_stall_cnt(c_cnt));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; id_valid = 1'b0; id_ex_mem_rd = 1'b0;
        id_ex_rd = 5'd0; id_src = '0; c_id_src = '0;
        fwd_rd = {5'd3, 5'd3}; fwd_wr_en = 2'b11; id_ex_src = {5'd0, 5'd3};
        c_id_ex_src = '0; c_fwd_rd = '0; c_wr_en = '0;
        #1;
        chk("rst_mux_forced", a_mux, 4'h0);
        chk("rst_stall_forced", {a_pc, a_ifid, a_bub}, 3'b000);
        tick();
        chk("rst_cnt_a", a_cnt, 2'd0);
        chk("rst_cnt_b", b_cnt, 32'd0);
        rst = 1'b1;

        // Forwarding priority and register-0 exclusion
        id_ex_src = {5'd8, 5'd3}; #1;
        chk("fwd_exmem_prio", a_mux, 4'h1);
        fwd_wr_en = 2'b10; id_ex_src = {5'd3, 5'd3}; #1;
        chk("fwd_memwb_only", a_mux, 4'hA);
        fwd_rd = '0; fwd_wr_en = 2'b11; id_ex_src = '0; #1;
        chk("fwd_reg0", a_mux, 4'h0);

        c_fwd_rd = {5'd7, 5'd4, 5'd6}; c_wr_en = 3'b111; c_id_ex_src = {5'd9, 5'd7, 5'd0}; #1;
        chk("fwd_stage2", c_mux, 6'h0C);
        c_wr_en = 3'b011; #1;
        chk("fwd_stage2_noen", c_mux, 6'h00);

        // Load-use on rt: LOAD_LAT=1 stalls one cycle, LOAD_LAT=3 three
        id_valid = 1'b1; id_ex_rd = 5'd5; id_src = {5'd5, 5'd1}; id_ex_mem_rd = 1'b1; #1;
        chk("lu_a_c1", {a_pc, a_ifid, a_bub}, 3'b111);
        chk("lu_b_c1", {b_pc, b_ifid, b_bub}, 3'b111);
        tick(); id_ex_mem_rd = 1'b0; #1;
        chk("lu_a_c2", {a_pc, a_ifid, a_bub}, 3'b000);
        chk("lu_a_cnt", a_cnt, 2'd1);
        chk("lu_b_c2", {b_pc, b_ifid, b_bub}, 3'b111);
        tick();
        chk("lu_b_c3", {b_pc, b_ifid, b_bub}, 3'b111);
        tick();
        chk("lu_b_c4", {b_pc, b_ifid, b_bub}, 3'b000);
        chk("lu_b_cnt", b_cnt, 32'd3);

        // Both operands hit the load target: still a single 3-cycle stall
        id_src = {5'd5, 5'd5}; id_ex_mem_rd = 1'b1; #1;
        chk("both_c1", {b_pc, b_ifid, b_bub}, 3'b111);
        tick(); id_ex_mem_rd = 1'b0;
        tick(); tick();
        chk("both_end", {b_pc, b_ifid, b_bub}, 3'b000);
        chk("both_cnt", b_cnt, 32'd6);

        // Flush beats a freshly detected hazard
        id_ex_mem_rd = 1'b1; flush = 1'b1; #1;
        chk("flush_idle", {a_pc, a_ifid, a_bub}, 3'b000);
        flush = 1'b0; id_ex_mem_rd = 1'b0;

        // Flush in the 2nd stall cycle of LOAD_LAT=3
        rst = 1'b0; tick(); rst = 1'b1; #1;
        chk("flush_rst_cnt", b_cnt, 32'd0);
        id_ex_mem_rd = 1'b1; #1;
        chk("flush_c1", {b_pc, b_ifid, b_bub}, 3'b111);
        tick(); id_ex_mem_rd = 1'b0; flush = 1'b1; #1;
        chk("flush_c2", {b_pc, b_ifid, b_bub}, 3'b000);
        tick(); flush = 1'b0; #1;
        chk("flush_c3_idle", {b_pc, b_ifid, b_bub}, 3'b000);
        chk("flush_cnt", b_cnt, 32'd1);

        // Reset pulse in the middle of a stall
        fwd_rd = {5'd3, 5'd3}; fwd_wr_en = 2'b11; id_ex_src = {5'd0, 5'd3};
        id_ex_mem_rd = 1'b1; #1;
        tick(); id_ex_mem_rd = 1'b0; #1;
        chk("rstmid_stalling", {b_pc, b_ifid, b_bub}, 3'b111);
        rst = 1'b0; #1;
        chk("rstmid_stall0", {b_pc, b_ifid, b_bub}, 3'b000);
        chk("rstmid_mux0", b_mux, 4'h0);
        tick(); rst = 1'b1; #1;
        chk("rstmid_idle", {b_pc, b_ifid, b_bub}, 3'b000);
        chk("rstmid_cnt", b_cnt, 32'd0);
        chk("rstmid_mux_back", b_mux, 4'h1);

        // Saturation of the 2-bit counter under a held hazard
        id_ex_mem_rd = 1'b1;
        tick(); tick();
        chk("sat_cnt2", a_cnt, 2'd2);
        tick(); tick(); tick();
        chk("sat_hold", a_cnt, 2'd3);
        id_ex_mem_rd = 1'b0; tick();

        // LOAD_LAT=2 on the wide build
        c_id_src = {5'd0, 5'd0, 5'd5}; id_ex_mem_rd = 1'b1; #1;
        chk("c_stall_c1", {c_pc, c_ifid, c_bub}, 3'b111);
        tick(); id_ex_mem_rd = 1'b0; #1;
        chk("c_stall_c2", {c_pc, c_ifid, c_bub}, 3'b111);
        tick();
        chk("c_stall_c3", {c_pc, c_ifid, c_bub}, 3'b000);
        chk("c_cnt", c_cnt, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
